// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

   localparam int DIV_W_DEFAULT = 16;
   localparam int ABS_W = 64;

   // Magnitude of an n-bit two's-complement value carried in a wide word.
   function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] v,
                                              input int n);
      logic [ABS_W-1:0] r;
      r = v;
      if (v[n-1]) r = ~v + 64'd1;
      return r;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {P,A}, trial-subtract B.
module div_step #(
   parameter int N = 16
) (
   input  logic [N:0]   p,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N:0]   p_next,
   output logic [N-1:0] a_next
);

   logic [N:0]   sp;
   logic [N-1:0] sa;
   logic [N:0]   t;

   assign sp = {p[N-1:0], a[N-1]};
   assign sa = {a[N-2:0], 1'b0};
   assign t  = sp - {1'b0, b};

   always_comb begin
      p_next = t;
      a_next = sa | {{(N-1){1'b0}}, 1'b1};
      if (t[N]) begin
         p_next = sp;
         a_next = sa;
      end
   end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider, signed/unsigned, valid/ready on both sides.
import div_pkg::*;

module seq_div #(
   parameter  int N  = DIV_W_DEFAULT,
   localparam int CW = $clog2(N+1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         is_signed,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_zero,
   output logic         overflow
);

   localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

   div_state_t state, state_nx;

   logic [CW-1:0] cnt;
   logic [N:0]    p, p_nx;
   logic [N-1:0]  a, a_nx, b, dvd;
   logic          q_neg, r_neg, dz, ovf;
   logic          accept, last;
   logic [N-1:0]  dvd_mag, dvs_mag;
   logic [N-1:0]  q_fix, r_fix;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready && !flush;
   assign last     = (cnt == CW'(N-1));

   // |MIN| = 2^(N-1) still fits as an unsigned N-bit magnitude.
   assign dvd_mag = is_signed ? N'(abs_n(ABS_W'(dividend), N)) : dividend;
   assign dvs_mag = is_signed ? N'(abs_n(ABS_W'(divisor), N)) : divisor;

   div_step #(.N(N)) u_step (
      .p      (p),
      .a      (a),
      .b      (b),
      .p_next (p_nx),
      .a_next (a_nx)
   );

   always_comb begin
      q_fix = q_neg ? -a : a;
      r_fix = r_neg ? -p[N-1:0] : p[N-1:0];
      if (dz) begin
         q_fix = '1;
         r_fix = dvd;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = CALC;
         CALC:    if (last) state_nx = FIX;
         FIX:     state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         p         <= '0;
         a         <= '0;
         b         <= '0;
         dvd       <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         dz        <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state <= state_nx;
         if (flush) begin
            out_valid <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (accept) begin
                     p     <= '0;
                     a     <= dvd_mag;
                     b     <= dvs_mag;
                     dvd   <= dividend;
                     cnt   <= '0;
                     q_neg <= is_signed & (dividend[N-1] ^ divisor[N-1]);
                     r_neg <= is_signed & dividend[N-1];
                     dz    <= (divisor == '0);
                     ovf   <= is_signed && dividend == MIN_V
                              && divisor == '1;
                  end
               end
               CALC: begin
                  p   <= p_nx;
                  a   <= a_nx;
                  cnt <= cnt + 1'b1;
               end
               FIX: begin
                  quotient  <= q_fix;
                  remainder <= r_fix;
                  div_zero  <= dz;
                  overflow  <= ovf;
                  out_valid <= 1'b1;
               end
               DONE: begin
                  if (out_ready) out_valid <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: randomized ops against an arithmetic model.
module tb_seq_div;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic         is_signed;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_zero;
   logic         overflow;

   seq_div #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
      logic         ovf;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   bit   prev_v = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(string nm, logic [31:0] got, logic [31:0] req);
      total++;
      if (got === req) passed++;
      else $display("FAIL %s: got %0h required %0h", nm, got, req);
   endtask

   task automatic timeout(string nm);
      total++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   // Reference: truncating division, defined results for /0 and MIN/-1.
   function automatic exp_t model(bit sg, logic [N-1:0] x, logic [N-1:0] y);
      exp_t   e;
      longint sx, sy;
      e.q = '0; e.r = '0; e.dz = 1'b0; e.ovf = 1'b0; e.acc = 0;
      if (y == 0) begin
         e.q  = 16'hFFFF;
         e.r  = x;
         e.dz = 1'b1;
      end else if (sg) begin
         sx = $signed(x);
         sy = $signed(y);
         if (sx == -32768 && sy == -1) begin
            e.q   = 16'h8000;
            e.r   = 16'h0000;
            e.ovf = 1'b1;
         end else begin
            e.q = 16'(sx / sy);
            e.r = 16'(sx % sy);
         end
      end else begin
         e.q = x / y;
         e.r = x % y;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready && !flush) acc_cnt++;
   end

   // Monitor: latency on rise, result comparison on handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_v = 1'b0;
      end else begin
         if (out_valid && !prev_v && sb.size() > 0)
            check("latency", 32'(cyc - sb[0].acc), 32'd17);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               $display("FAIL unexpected_result: got q=%h r=%h, required none",
                        quotient, remainder);
            end else begin
               e = sb.pop_front();
               check("quotient", 32'(quotient), 32'(e.q));
               check("remainder", 32'(remainder), 32'(e.r));
               check("div_zero", 32'(div_zero), 32'(e.dz));
               check("overflow", 32'(overflow), 32'(e.ovf));
            end
         end
         prev_v = out_valid;
      end
   end

   // Present one op, push its expectation at the accept edge.
   task automatic issue(bit sg, logic [N-1:0] x, logic [N-1:0] y);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      in_valid  = 1'b1;
      is_signed = sg;
      dividend  = x;
      divisor   = y;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (in_ready && !flush) begin
            e = model(sg, x, y);
            e.acc = cyc + 1;
            sb.push_back(e);
            ok = 1'b1;
         end
      end
      if (!ok) timeout("accept");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = (sb.size() == 0);
      for (int k = 0; k < 100 && !ok; k++) begin
         @(posedge clk);
         if (sb.size() == 0) ok = 1'b1;
      end
      if (!ok) begin
         timeout("result");
         sb.delete();
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int quiet;
      int a0;
      bit ok;
      logic [N-1:0] rx, ry;
      bit rs;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; is_signed = 1'b0;
      dividend = '0; divisor = '0; out_ready = 1'b1;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_flags", 32'({div_zero, overflow}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      issue(1'b0, 16'd100, 16'd7);
      drain();
      check("in_ready_after_hs", 32'(in_ready), 32'd1);
      check("out_valid_after_hs", 32'(out_valid), 32'd0);

      issue(1'b1, 16'hFFF9, 16'd2);
      drain();
      issue(1'b1, 16'd7, 16'hFFFE);
      drain();

      issue(1'b0, 16'h04D2, 16'h0000);
      drain();
      issue(1'b1, 16'h8000, 16'hFFFF);
      drain();
      issue(1'b0, 16'h8000, 16'hFFFF);
      drain();

      // Stalled consumer: result must hold while out_ready is low.
      out_ready = 1'b0;
      issue(1'b0, 16'hFFFF, 16'h0001);
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         if (out_valid) ok = 1'b1;
      end
      if (!ok) timeout("stall_valid");
      for (int k = 0; k < 5; k++) begin
         check("stall_q", 32'(quotient), 32'h0000FFFF);
         check("stall_r", 32'(remainder), 32'd0);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_valid", 32'(out_valid), 32'd1);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stall_done_valid", 32'(out_valid), 32'd0);
      check("stall_done_ready", 32'(in_ready), 32'd1);
      check("stall_sb_empty", 32'(sb.size()), 32'd0);

      // Flush in the middle of the iteration.
      issue(1'b0, 16'd1000, 16'd3);
      repeat (7) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      sb.delete();
      check("flush_in_ready", 32'(in_ready), 32'd1);
      quiet = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (out_valid) quiet++;
      end
      check("flush_no_result", 32'(quiet), 32'd0);
      @(posedge clk);
      #1;
      issue(1'b0, 16'd50, 16'd5);
      drain();

      // Asynchronous reset mid-iteration.
      issue(1'b1, 16'hFB2E, 16'd37);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_quotient", 32'(quotient), 32'd0);
      check("arst_remainder", 32'(remainder), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_flags", 32'({div_zero, overflow}), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back with in_valid held high.
      a0 = acc_cnt;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         rs = 1'($urandom_range(0, 1));
         rx = 16'($urandom);
         ry = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         is_signed = rs;
         dividend  = rx;
         divisor   = ry;
         ok = 1'b0;
         for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
               e = model(rs, rx, ry);
               e.acc = cyc + 1;
               sb.push_back(e);
               ok = 1'b1;
            end
         end
         if (!ok) timeout("b2b_accept");
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain();
      check("b2b_accepts", 32'(acc_cnt - a0), 32'd4);

      for (int i = 0; i < 12; i++) begin
         rs = 1'($urandom_range(0, 1));
         rx = 16'($urandom);
         ry = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom_range(0, 300));
         issue(rs, rx, ry);
         drain();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seq_div.md
Name: seq_div

Overview:
- Parametrised multi-cycle restoring divider for the CPU execute stage.
- Computes quotient and remainder together, in signed or unsigned mode, selected per operation.
- Uses a valid/ready handshake on both the operand side and the result side.
- Flags divide-by-zero and signed overflow with fixed, defined results, and supports a synchronous flush for pipeline squash.

Parameters:
- N, 16, operand/result width in bits (N >= 4).
- CW, $clog2(N+1), width of the iteration counter (derived, not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous abort: return to IDLE and drop any in-flight or pending result.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, divider can accept operands.
- is_signed, input, 1, 1 = two's-complement division, 0 = unsigned; sampled at accept.
- dividend, input, N, numerator; sampled at accept.
- divisor, input, N, denominator; sampled at accept.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- quotient, output, N, quotient.
- remainder, output, N, remainder.
- div_zero, output, 1, divisor was 0.
- overflow, output, 1, signed MIN / -1 case.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (rst_n low, any time including mid-operation):
  - state = IDLE, counter = 0.
  - out_valid = 0, quotient = 0, remainder = 0, div_zero = 0, overflow = 0.
  - in_ready = 1 after reset is released.
- in_ready = (state == IDLE). Not registered separately.
- Accept occurs on a rising edge with in_valid && in_ready && !flush. At accept:
  - Latch magnitudes: |dividend| and |divisor| when is_signed, raw values otherwise. |MIN| = 2^(N-1) fits in N bits unsigned.
  - Latch sign flags: q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend). Both are 0 when unsigned.
  - Latch dz = (divisor == 0) and ovf = is_signed && dividend == MIN && divisor == all-ones.
  - Clear the partial remainder P (N+1 bits), counter = 0, state -> CALC.
- CALC, one restoring step per cycle for exactly N cycles:
  - {P, A} shift left by 1.
  - T = P - {1'b0, B}.
  - If T[N] == 1: A[0] = 0 and P is unchanged (restore). Otherwise P = T and A[0] = 1.
  - After the Nth step, state -> FIX.
- FIX, one cycle:
  - quotient = q_neg ? -A : A; remainder = r_neg ? -P[N-1:0] : P[N-1:0].
  - If dz: override quotient = all-ones, remainder = original dividend (kept latched).
  - If ovf: quotient = MIN, remainder = 0 (falls out of the arithmetic; no override required).
  - Drive div_zero = dz and overflow = ovf; out_valid = 1; state -> DONE.
- Latency: out_valid rises N+1 cycles after the accept edge, for every case including dz. There is no early-out.
- DONE:
  - Outputs hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid = 0, state -> IDLE.
  - Throughput is one operation per N+3 cycles at minimum.
- Output registers while not in DONE: quotient, remainder, div_zero and overflow keep their last values. Consumers use them only when out_valid = 1.
- flush:
  - Highest priority after reset; effective in every state.
  - Next state IDLE, out_valid = 0, and any pending result is discarded.
  - flush in the same cycle as in_valid means no accept.
- Input changes outside the accept edge have no effect.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] div_state_t {IDLE, CALC, FIX, DONE}.
  - localparam DIV_W_DEFAULT = 16.
  - function abs_n (N-bit magnitude).
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: P (N+1 bits), A (N bits), B (N bits).
  - Outputs: next P, next A.
  - Instantiated once in seq_div and unit-testable on its own.

Test Plan (N=16):
1. Unsigned 100 / 7, out_ready held 1 -> quotient = 14, remainder = 2, flags 0; out_valid exactly 17 cycles after accept, in_ready returns 1 the cycle after the handshake.
2. Signed -7 / 2, then 7 / -2 -> 0xFFFD / 0xFFFF (q = -3, r = -1), then 0xFFFD / 0x0001 (q = -3, r = 1).
3. Edge cases:
   - Unsigned 0x04D2 / 0 -> quotient 0xFFFF, remainder 0x04D2, div_zero = 1, same 17-cycle latency.
   - Signed 0x8000 / 0xFFFF -> quotient 0x8000, remainder 0, overflow = 1.
   - Unsigned 0x8000 / 0xFFFF -> quotient 0, remainder 0x8000.
4. Unsigned 0xFFFF / 1 with out_ready low for 5 cycles after out_valid:
   - quotient 0xFFFF, remainder 0 held stable, in_ready = 0 throughout.
   - Completes on the cycle out_ready rises.
5. Abort cases:
   - flush asserted at CALC cycle 8 -> out_valid never rises, in_ready = 1 next cycle.
   - Next op 50 / 5 -> quotient 10, remainder 0.
   - Repeat with rst_n pulsed low mid-CALC -> all outputs 0 immediately (asynchronously).
6. Back-to-back with in_valid held high across 4 random ops -> exactly one accept per op, each accept only in IDLE, results match a reference model (signed and unsigned, random including 0 divisors).
